// File: rtl/csr_regfile.sv
// csr_regfile: CSR file answering WB-stage reads/masked writes, committing wb_ex/ertn state.
// Optional stable timer (TID/TCFG/TVAL/TICLR, ESTAT.IS[11]) enabled by defining CSR_TIMER_EN.
module csr_regfile #(
  parameter logic [31:0] TID_RESET    = 32'h0,
  parameter logic [31:0] EENTRY_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_num,
  input  logic        csr_re,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        ertn_flush,
  input  logic        wb_ex,
  input  logic [31:0] wb_csr_pc,
  input  logic [31:0] wb_vaddr,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic [1:0]  crmd_plv
);
  localparam logic [13:0] A_CRMD   = 14'h00;
  localparam logic [13:0] A_PRMD   = 14'h01;
  localparam logic [13:0] A_ECFG   = 14'h04;
  localparam logic [13:0] A_ESTAT  = 14'h05;
  localparam logic [13:0] A_ERA    = 14'h06;
  localparam logic [13:0] A_BADV   = 14'h07;
  localparam logic [13:0] A_EENTRY = 14'h0c;
  localparam logic [13:0] A_SAVE0  = 14'h30;
  localparam logic [13:0] A_SAVE1  = 14'h31;
  localparam logic [13:0] A_SAVE2  = 14'h32;
  localparam logic [13:0] A_SAVE3  = 14'h33;
  localparam logic [13:0] A_TID    = 14'h40;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  logic [8:0]       crmd;
  logic [1:0]       pplv;
  logic             pie;
  logic [12:0]      lie;
  logic [1:0]       is_sw;
  logic [7:0]       is_hw;
  logic             is_ipi;
  logic             timer_is;
  logic [12:0]      estat_is;
  logic [5:0]       ecode;
  logic [8:0]       esubcode;
  logic [31:0]      era;
  logic [31:0]      badv;
  logic [25:0]      eentry;
  logic [3:0][31:0] save;
  logic [31:0]      tid;
  logic [31:0]      tcfg;
  logic [31:0]      tval;
  logic [31:0]      rd;
  logic [31:0]      wk;
  logic [31:0]      wv;
  logic             we;
  // Lower-priority events are dropped whole when a higher one commits.
  assign we = csr_we & ~wb_ex & ~ertn_flush;
  assign wk = ~csr_wmask;
  assign wv = csr_wvalue & csr_wmask;
  assign estat_is = {is_ipi, timer_is, 1'b0, is_hw, is_sw};
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd     <= 9'h8;
      pplv     <= 2'h0;
      pie      <= 1'b0;
      lie      <= 13'h0;
      is_sw    <= 2'h0;
      ecode    <= 6'h0;
      esubcode <= 9'h0;
      era      <= 32'h0;
      badv     <= 32'h0;
      eentry   <= EENTRY_RESET[31:6];
      save     <= '0;
    end else if (wb_ex) begin
      pplv      <= crmd[1:0];
      pie       <= crmd[2];
      crmd[2:0] <= 3'h0;
      era       <= wb_csr_pc;
      ecode     <= wb_ecode;
      esubcode  <= wb_esubcode;
      if (wb_ecode == 6'h08 || wb_ecode == 6'h09) badv <= wb_vaddr;
    end else if (ertn_flush) begin
      crmd[2:0] <= {pie, pplv};
    end else if (csr_we) begin
      case (csr_num)
        A_CRMD:   crmd <= crmd & wk[8:0] | wv[8:0];
        A_PRMD:   {pie, pplv} <= {pie, pplv} & wk[2:0] | wv[2:0];
        A_ECFG:   lie <= (lie & wk[12:0] | wv[12:0]) & 13'h1bff;
        A_ESTAT:  is_sw <= is_sw & wk[1:0] | wv[1:0];
        A_ERA:    era <= era & wk | wv;
        A_BADV:   badv <= badv & wk | wv;
        A_EENTRY: eentry <= eentry & wk[31:6] | wv[31:6];
        A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: save[csr_num[1:0]] <= save[csr_num[1:0]] & wk | wv;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      is_hw  <= 8'h0;
      is_ipi <= 1'b0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
    end
  end
`ifdef CSR_TIMER_EN
  localparam logic [13:0] A_TICLR = 14'h44;
  logic [31:0] tcfg_new;
  logic        tcfg_load;
  logic        ticlr;
  logic        fire;
  assign tcfg_new  = tcfg & wk | wv;
  assign tcfg_load = we && csr_num == A_TCFG && tcfg_new[0];
  assign ticlr     = we && csr_num == A_TICLR && wv[0];
  assign fire      = !tcfg_load && tcfg[0] && tval == 32'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      tid      <= TID_RESET;
      tcfg     <= 32'h0;
      tval     <= 32'h0;
      timer_is <= 1'b0;
    end else begin
      if (we && csr_num == A_TID) tid <= tid & wk | wv;
      if (we && csr_num == A_TCFG) tcfg <= tcfg_new;
      if (tcfg_load) tval <= {tcfg_new[31:2], 2'b00};
      else if (tcfg[0] && tval != 32'h0) tval <= tval - 32'd1;
      else if (tcfg[0] && tcfg[1]) tval <= {tcfg[31:2], 2'b00};
      timer_is <= fire | (timer_is & ~ticlr);
    end
  end
`else
  logic unused_tid_reset;
  assign unused_tid_reset = ^TID_RESET;
  assign tid      = 32'h0;
  assign tcfg     = 32'h0;
  assign tval     = 32'h0;
  assign timer_is = 1'b0;
`endif
  always_comb begin
    rd = 32'h0;
    case (csr_num)
      A_CRMD:   rd = {23'h0, crmd};
      A_PRMD:   rd = {29'h0, pie, pplv};
      A_ECFG:   rd = {19'h0, lie};
      A_ESTAT:  rd = {1'b0, esubcode, ecode, 3'h0, estat_is};
      A_ERA:    rd = era;
      A_BADV:   rd = badv;
      A_EENTRY: rd = {eentry, 6'h0};
      A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: rd = save[csr_num[1:0]];
      A_TID:    rd = tid;
      A_TCFG:   rd = tcfg;
      A_TVAL:   rd = tval;
      default:  rd = 32'h0;
    endcase
  end
  assign csr_rvalue = csr_re ? rd : 32'h0;
  assign has_int    = crmd[2] & |(estat_is & lie);
  assign ex_entry   = {eentry, 6'h0};
  assign ertn_entry = era;
  assign crmd_plv   = crmd[1:0];
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed plan scenarios plus randomized traffic checked against a
// table-driven CSR array model; timer scenarios follow CSR_TIMER_EN.
module tb_csr_regfile;
  localparam logic [31:0] TID_R = 32'h1234_5678;
  localparam logic [31:0] EEN_R = 32'h1c00_0abc;
`ifdef CSR_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif
  localparam logic [13:0] CRMD = 14'h00, PRMD = 14'h01, ECFG = 14'h04, ESTAT = 14'h05;
  localparam logic [13:0] ERA = 14'h06, BADV = 14'h07, EENTRY = 14'h0c, SAVE0 = 14'h30;
  localparam logic [13:0] TID = 14'h40, TCFG = 14'h41, TVAL = 14'h42, TICLR = 14'h44;
  logic clk = 1'b0, reset = 1'b1;
  logic [13:0] csr_num = '0;
  logic csr_re = 1'b0, csr_we = 1'b0, ertn_flush = 1'b0, wb_ex = 1'b0, ipi_int_in = 1'b0;
  logic [31:0] csr_wmask = '0, csr_wvalue = '0, wb_csr_pc = '0, wb_vaddr = '0;
  logic [5:0] wb_ecode = '0;
  logic [8:0] wb_esubcode = '0;
  logic [7:0] hw_int_in = '0;
  logic [31:0] csr_rvalue, ex_entry, ertn_entry;
  logic has_int;
  logic [1:0] crmd_plv;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mreg [0:68];
  logic [13:0] alist [18] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0c, 14'h30,
                              14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02,
                              14'h45, 14'h3fff};

  csr_regfile #(.TID_RESET(TID_R), .EENTRY_RESET(EEN_R)) dut (
    .clk(clk), .reset(reset), .csr_num(csr_num), .csr_re(csr_re), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .ertn_flush(ertn_flush),
    .wb_ex(wb_ex), .wb_csr_pc(wb_csr_pc), .wb_vaddr(wb_vaddr), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry), .crmd_plv(crmd_plv));

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Software-writable bits of each address; zero means read-only or unmapped.
  function automatic logic [31:0] wmask(input logic [13:0] a);
    case (a)
      CRMD:   return 32'h1ff;
      PRMD:   return 32'h7;
      ECFG:   return 32'h1bff;
      ESTAT:  return 32'h3;
      EENTRY: return 32'hffff_ffc0;
      ERA, BADV, 14'h30, 14'h31, 14'h32, 14'h33: return 32'hffff_ffff;
      TID, TCFG: return TMR ? 32'hffff_ffff : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [13:0] a);
    return (a <= 14'h44) ? mreg[a] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= 68; i++) mreg[i] = 32'h0;
    mreg[CRMD] = 32'h8;
    mreg[EENTRY] = EEN_R & 32'hffff_ffc0;
    mreg[TID] = TMR ? TID_R : 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] o [0:68];
    logic [31:0] wm;
    logic dwe, fire;
    o = mreg;
    dwe = csr_we && !wb_ex && !ertn_flush;
    fire = 1'b0;
    if (wb_ex) begin
      mreg[PRMD] = (o[PRMD] & ~32'h7) | (o[CRMD] & 32'h7);
      mreg[CRMD] = o[CRMD] & ~32'h7;
      mreg[ERA] = wb_csr_pc;
      mreg[ESTAT] = (o[ESTAT] & 32'h0000_ffff) | {1'b0, wb_esubcode, wb_ecode, 16'h0};
      if (wb_ecode inside {6'h08, 6'h09}) mreg[BADV] = wb_vaddr;
    end else if (ertn_flush) begin
      mreg[CRMD] = (o[CRMD] & ~32'h7) | (o[PRMD] & 32'h7);
    end else if (dwe && csr_num <= 14'h44) begin
      wm = wmask(csr_num) & csr_wmask;
      mreg[csr_num] = (o[csr_num] & ~wm) | (csr_wvalue & wm);
    end
    mreg[ESTAT][9:2] = hw_int_in;
    mreg[ESTAT][12] = ipi_int_in;
    if (TMR) begin
      if (dwe && csr_num == TCFG && mreg[TCFG][0]) mreg[TVAL] = mreg[TCFG] & ~32'h3;
      else if (o[TCFG][0] && o[TVAL] != 0) begin
        mreg[TVAL] = o[TVAL] - 1;
        fire = (o[TVAL] == 1);
      end else if (o[TCFG][0] && o[TCFG][1]) mreg[TVAL] = o[TCFG] & ~32'h3;
      if (fire) mreg[ESTAT][11] = 1'b1;
      else if (dwe && csr_num == TICLR && csr_wmask[0] && csr_wvalue[0]) mreg[ESTAT][11] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    reset = 1'b0; csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
  endtask

  task automatic peek(input logic [13:0] a, output logic [31:0] v);
    csr_num = a; csr_re = 1'b1;
    #1 v = csr_rvalue;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
    csr_num = a; csr_re = 1'b1; csr_we = 1'b1; csr_wmask = m; csr_wvalue = v;
    tick();
  endtask

  task automatic chk_out(input string tag);
    logic [31:0] hi;
    hi = {31'h0, mreg[CRMD][2] & |(mreg[ESTAT][12:0] & mreg[ECFG][12:0])};
    check({tag, ".has_int"}, {31'h0, has_int}, hi);
    check({tag, ".ex_entry"}, ex_entry, mreg[EENTRY]);
    check({tag, ".ertn_entry"}, ertn_entry, mreg[ERA]);
    check({tag, ".plv"}, {30'h0, crmd_plv}, mreg[CRMD] & 32'h3);
  endtask

  initial begin
    logic [31:0] v;
    logic [13:0] a;
    tick();
    peek(CRMD, v);   check("rst.crmd", v, 32'h8);
    peek(EENTRY, v); check("rst.eentry", v, 32'h1c00_0a80);
    peek(TID, v);    check("rst.tid", v, TMR ? TID_R : 32'h0);
    check("rst.has_int", {31'h0, has_int}, 32'h0);
    check("rst.plv", {30'h0, crmd_plv}, 32'h0);
    // masked write; same-cycle read still sees the old value
    csr_num = CRMD; csr_re = 1'b1; csr_we = 1'b1; csr_wmask = 32'h7; csr_wvalue = 32'h5;
    #1 check("t1.same_cycle", csr_rvalue, 32'h8);
    tick();
    peek(CRMD, v); check("t1.crmd", v, 32'hd);
    csr_re = 1'b0;
    #1 check("t1.re_low", csr_rvalue, 32'h0);
    // exception entry and return
    wr(CRMD, 32'h7, 32'h7);
    wb_ex = 1'b1; wb_csr_pc = 32'h1c00_0100; wb_ecode = 6'h09; wb_esubcode = 9'h0;
    wb_vaddr = 32'h8000_0003;
    tick();
    peek(PRMD, v);  check("t2.prmd", v, 32'h7);
    peek(CRMD, v);  check("t2.crmd", v, 32'h8);
    peek(ERA, v);   check("t2.era", v, 32'h1c00_0100);
    peek(BADV, v);  check("t2.badv", v, 32'h8000_0003);
    peek(ESTAT, v); check("t2.ecode", (v >> 16) & 32'h3f, 32'h9);
    check("t2.ertn_entry", ertn_entry, 32'h1c00_0100);
    ertn_flush = 1'b1;
    tick();
    peek(CRMD, v); check("t2.ertn_crmd", v, 32'hf);
    check("t2.plv", {30'h0, crmd_plv}, 32'h3);
    // priority: only the exception commits
    wb_ex = 1'b1; ertn_flush = 1'b1; wb_csr_pc = 32'h1c00_0200; wb_ecode = 6'h0b;
    wb_vaddr = 32'h1234;
    csr_num = SAVE0; csr_we = 1'b1; csr_wmask = 32'hffff_ffff; csr_wvalue = 32'hdead;
    tick();
    peek(SAVE0, v); check("t3.save0", v, 32'h0);
    peek(CRMD, v);  check("t3.crmd", v, 32'h8);
    peek(ERA, v);   check("t3.era", v, 32'h1c00_0200);
    peek(BADV, v);  check("t3.badv_hold", v, 32'h8000_0003);
    // interrupt line sampling and masking
    hw_int_in = 8'h01;
    tick();
    peek(ESTAT, v); check("t6.estat", v, 32'h000b_0004);
    wr(ECFG, 32'hffff_ffff, 32'h4);
    check("t6.has_int_ie0", {31'h0, has_int}, 32'h0);
    wr(CRMD, 32'h4, 32'h4);
    check("t6.has_int", {31'h0, has_int}, 32'h1);
    wr(ESTAT, 32'hffff_ffff, 32'hffff);
    peek(ESTAT, v); check("t6.estat_wr", v, 32'h000b_0007);
    wr(ECFG, 32'hffff_ffff, 32'hffff_ffff);
    peek(ECFG, v); check("t6.ecfg", v, 32'h1bff);
    hw_int_in = 8'h0;
    wr(ECFG, 32'hffff_ffff, 32'h0);
    wr(ESTAT, 32'h3, 32'h0);
    peek(ESTAT, v); check("t6.estat_clr", v, 32'h000b_0000);
`ifdef CSR_TIMER_EN
    // one-shot timer
    wr(ECFG, 32'hffff_ffff, 32'h800);
    wr(TCFG, 32'hffff_ffff, 32'h9);
    peek(TVAL, v); check("t4.load", v, 32'h8);
    for (int k = 1; k <= 8; k++) begin
      tick();
      peek(TVAL, v);  check("t4.tval", v, 32'(8 - k));
      peek(ESTAT, v); check("t4.is11", {31'h0, v[11]}, {31'h0, k == 8});
    end
    check("t4.has_int", {31'h0, has_int}, 32'h1);
    tick();
    peek(TVAL, v); check("t4.hold0", v, 32'h0);
    wr(TICLR, 32'h1, 32'h1);
    peek(ESTAT, v); check("t4.ticlr", {31'h0, v[11]}, 32'h0);
    check("t4.has_int_clr", {31'h0, has_int}, 32'h0);
    peek(TICLR, v); check("t4.ticlr_rd", v, 32'h0);
    // periodic timer, clear racing a set
    wr(TCFG, 32'hffff_ffff, 32'hb);
    for (int k = 0; k < 8; k++) tick();
    peek(TVAL, v); check("t5.zero", v, 32'h0);
    tick();
    peek(TVAL, v); check("t5.reload", v, 32'h8);
    wr(TICLR, 32'h1, 32'h1);
    peek(ESTAT, v); check("t5.clr", {31'h0, v[11]}, 32'h0);
    for (int k = 0; k < 6; k++) tick();
    peek(TVAL, v); check("t5.one", v, 32'h1);
    wr(TICLR, 32'h1, 32'h1);
    peek(ESTAT, v); check("t5.set_wins", {31'h0, v[11]}, 32'h1);
    // reset mid-countdown
    wr(TCFG, 32'hffff_ffff, 32'h9);
    tick();
    reset = 1'b1;
    tick();
    peek(TVAL, v);  check("rst2.tval", v, 32'h0);
    peek(TCFG, v);  check("rst2.tcfg", v, 32'h0);
    peek(ESTAT, v); check("rst2.estat", v, 32'h0);
`else
    wr(TCFG, 32'hffff_ffff, 32'hb);
    tick();
    peek(TCFG, v); check("notmr.tcfg", v, 32'h0);
    peek(TVAL, v); check("notmr.tval", v, 32'h0);
    reset = 1'b1;
    tick();
    peek(ESTAT, v); check("rst2.estat", v, 32'h0);
`endif
    peek(CRMD, v); check("rst2.crmd", v, 32'h8);
    for (int i = 0; i < 18; i++) begin
      peek(alist[i], v);
      check("dir.model", v, mread(alist[i]));
    end
    chk_out("dir");
    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      a = alist[$urandom_range(0, 17)];
      csr_num = a;
      csr_re = $urandom_range(0, 3) != 0;
      csr_we = $urandom_range(0, 1) == 1;
      csr_wmask = $urandom;
      csr_wvalue = (a == TCFG) ? 32'($urandom_range(0, 31)) : $urandom;
      wb_ex = $urandom_range(0, 15) == 0;
      ertn_flush = $urandom_range(0, 15) == 0;
      wb_csr_pc = $urandom;
      wb_vaddr = $urandom;
      wb_ecode = $urandom_range(0, 1) ? 6'(8 + $urandom_range(0, 1)) : 6'($urandom);
      wb_esubcode = 9'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        hw_int_in = 8'($urandom);
        ipi_int_in = 1'($urandom);
      end
      reset = $urandom_range(0, 199) == 0;
      #1 check("rnd.read", csr_rvalue, csr_re ? mread(a) : 32'h0);
      tick();
      chk_out("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control/status register file; the responder end of the WB-stage CSR interface.
- Services combinational CSR reads and clocked masked CSR writes issued by WB.
- Commits exception entry (wb_ex) and ertn return state; runs the stable timer.
- Exports exception/return target PCs to IF and the pending-interrupt flag to ID.

Parameters:
TID_RESET, 32'h0, reset value of TID
EENTRY_RESET, 32'h0, reset value of EENTRY

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
csr_num  in  14  CSR address from WB
csr_re  in  1  read enable
csr_rvalue  out  32  read data, combinational
csr_we  in  1  write enable
csr_wmask  in  32  per-bit write mask
csr_wvalue  in  32  write data
ertn_flush  in  1  ertn committing in WB
wb_ex  in  1  exception committing in WB
wb_csr_pc  in  32  PC of the excepting instruction
wb_vaddr  in  32  faulting address for BADV
wb_ecode  in  6  exception code
wb_esubcode  in  9  exception subcode
hw_int_in  in  8  hardware interrupt lines, level
ipi_int_in  in  1  inter-processor interrupt, level
has_int  out  1  enabled interrupt pending, to ID
ex_entry  out  32  EENTRY value, to IF
ertn_entry  out  32  ERA value, to IF
crmd_plv  out  2  current privilege level

Behaviour:
- Address map: CRMD 0x00, PRMD 0x01, ECFG 0x04, ESTAT 0x05, ERA 0x06, BADV 0x07, EENTRY 0x0C, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- Unmapped addresses read 0; writes to them are ignored.
- Read: csr_rvalue = csr_re ? register(csr_num) : 0. Zero latency; reflects pre-edge state in the same cycle as a write.
- Write: new = (old & ~csr_wmask) | (csr_wvalue & csr_wmask), applied to writable fields only; read-only and reserved bits hold.
- Update priority per cycle: wb_ex > ertn_flush > csr_we. A lower-priority event is dropped entirely when a higher one is asserted in the same cycle.
- Timer and interrupt sampling run regardless of these events.
- Reset values:
  - CRMD = 32'h8 (DA=1, PLV=0, IE=0).
  - PRMD, ECFG, ESTAT, ERA, BADV, SAVE0-3, TCFG, TVAL = 0.
  - EENTRY = EENTRY_RESET with [5:0] forced 0; TID = TID_RESET.
  - has_int = 0; crmd_plv = 0.
- CRMD fields: PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7], all writable; [31:9] read 0.
- PRMD fields: PPLV[1:0], PIE[2] writable.
- ECFG: LIE[9:0] and LIE[12:11] writable; bit 10 reads 0.
- ESTAT:
  - IS[1:0] software writable.
  - IS[9:2] <= hw_int_in every cycle; IS[12] <= ipi_int_in every cycle.
  - IS[11] is the timer flag.
  - Ecode[21:16] and EsubCode[30:22] are written only by wb_ex.
- wb_ex:
  - PRMD.PPLV <= CRMD.PLV; PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0; CRMD.IE <= 0.
  - ERA <= wb_csr_pc; Ecode <= wb_ecode; EsubCode <= wb_esubcode.
  - BADV <= wb_vaddr only when wb_ecode is 6'h08 (ADEF) or 6'h09 (ALE); otherwise BADV holds.
- ertn_flush: CRMD.PLV <= PRMD.PPLV; CRMD.IE <= PRMD.PIE.
- ERA, BADV, EENTRY[31:6], SAVE0-3 and TID are fully writable via csr_we.
- TCFG fields: En[0], Periodic[1], InitVal[31:2].
- TVAL:
  - A TCFG write leaving En=1 loads TVAL <= {InitVal_new, 2'b00} the same edge; that write overrides any countdown action.
  - Otherwise, with En=1 and TVAL!=0: TVAL <= TVAL-1.
  - On the 1->0 transition, IS[11] <= 1.
  - With TVAL==0 and Periodic=1: reload {InitVal, 2'b00}. With TVAL==0 and Periodic=0: hold at 0.
  - En=0 freezes TVAL. TVAL is read-only.
- TICLR: a write with mask & value bit0 = 1 clears IS[11]. If a timer set lands on the same edge, the set wins. TICLR reads 0.
- Outputs:
  - has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registers.
  - ex_entry = EENTRY; ertn_entry = ERA; crmd_plv = CRMD.PLV.
- Reset asserted mid-countdown returns all state to reset values on that edge; no pending timer flag survives.

Optional Feature:
- Macro: CSR_TIMER_EN.
- Defined: TID/TCFG/TVAL/TICLR and the IS[11] logic are implemented as above.
- Undefined: those four addresses read 0 and ignore writes; IS[11] is tied to 0; no timer storage is synthesized.

Test Plan:
1. Masked write: CRMD write, mask 32'h7, value 32'h5 -> next-cycle read CRMD = 32'hD. Same-cycle read returns the old value 32'h8.
2. Exception entry and return:
   - Stimulus: CRMD = 32'h7; wb_ex with pc 32'h1c000100, ecode 6'h09, vaddr 32'h8000_0003.
   - Response: PRMD = 32'h7, CRMD = 32'h8, ERA = 32'h1c000100, BADV = 32'h8000_0003, ESTAT[21:16] = 6'h09, ertn_entry = 32'h1c000100.
   - Follow-up: ertn_flush restores CRMD = 32'hF.
3. Priority: wb_ex, ertn_flush and csr_we (SAVE0 <- 32'hDEAD) asserted in one cycle -> only exception effects apply; SAVE0 unchanged.
4. One-shot timer:
   - Stimulus: TCFG <- 32'h9 (InitVal 2, En 1, Periodic 0).
   - Response: TVAL = 8, then 7...0 over 8 cycles; IS[11] = 1 on reaching 0; TVAL holds 0.
   - With ECFG.LIE[11] = 1 and CRMD.IE = 1, has_int = 1. A TICLR write of 1 clears both.
5. Periodic timer: TCFG <- 32'hB -> TVAL reloads 8 one cycle after reaching 0. A TICLR clear on the same edge as the next set leaves IS[11] = 1.
6. Interrupt line: hw_int_in = 8'h01 -> IS[2] = 1 the next cycle; has_int follows ECFG.LIE[2] & CRMD.IE. A write of 32'hFFFF to ESTAT changes only IS[1:0].
